// File: rtl/uart_rx_fifo_reader_pkg.sv
// Shared types and constants for the UART-to-processor FIFO read side.
package uart_rx_fifo_reader_pkg;

    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned UART_DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        VALID
    } rd_state_t;

endpackage

// File: rtl/uart_rx_fifo_reader_if.sv
// FIFO-side and processor-side signals of the read controller.
interface uart_rx_fifo_reader_if
    import uart_rx_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W
) ();

    logic              comp_empty;
    addr_t             r_add;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [15:0]       rd_count;

    modport master (
        input  comp_empty,
        input  mem_rd_data,
        input  rx_ready,
        output r_add,
        output mem_rd_en,
        output rx_data,
        output rx_valid,
        output rd_count
    );

    modport slave (
        output comp_empty,
        output mem_rd_data,
        output rx_ready,
        input  r_add,
        input  mem_rd_en,
        input  rx_data,
        input  rx_valid,
        input  rd_count
    );

endinterface

// File: rtl/uart_rx_fifo_reader_rd_ptr_counter.sv
// rd_ptr_counter: binary read pointer with increment enable and async active-low clear.
module uart_rx_fifo_reader_rd_ptr_counter
    import uart_rx_fifo_reader_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  en_i,
    output addr_t cnt_o
);

    addr_t cnt_q, cnt_d;

    // Natural binary wrap at 2^ADDR_W matches the comparator's pointer space.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_rx_fifo_reader.sv
// Processor-side read controller: fetches FIFO words while non-empty and
// presents each one on a valid/ready handshake.
module uart_rx_fifo_reader
    import uart_rx_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input logic                   processor_clk,
    input logic                   reset,
    uart_rx_fifo_reader_if.master bus
);

    rd_state_t         state_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic [15:0]       rd_count_q;
    logic              fetch;

    // Memory samples r_add at the edge closing FETCH, the same edge that advances it.
    assign fetch = (state_q == FETCH);

    uart_rx_fifo_reader_rd_ptr_counter u_rd_ptr_counter (
        .clk_i  (processor_clk),
        .rst_ni (reset),
        .en_i   (fetch),
        .cnt_o  (bus.r_add)
    );

    always_ff @(posedge processor_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.comp_empty) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    rx_data_q  <= bus.mem_rd_data;
                    rx_valid_q <= 1'b1;
                    state_q    <= VALID;
                end
                VALID: begin
                    if (bus.rx_ready) begin
                        rd_count_q <= rd_count_q + 16'd1;
                        rx_valid_q <= 1'b0;
                        state_q    <= bus.comp_empty ? IDLE : FETCH;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = fetch;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rd_count  = rd_count_q;

endmodule

// File: tb/tb_uart_rx_fifo_reader.sv
// Bench for uart_rx_fifo_reader: FIFO writer/memory/synchronizer model plus data scoreboard.
module tb_uart_rx_fifo_reader;
    import uart_rx_fifo_reader_pkg::*;

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic clk;
    logic reset;
    logic wr_en;
    logic [7:0] wr_data;

    uart_rx_fifo_reader_if #(.DATA_W(8)) bus_if ();

    uart_rx_fifo_reader #(.DATA_W(8)) dut (
        .processor_clk (clk),
        .reset         (reset),
        .bus           (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO environment: memory, write pointer, 2-FF synchronizer, empty comparator.
    logic [7:0]  mem [Depth];
    addr_t       w_ptr, ws1, ws2;
    logic [7:0]  rd_data_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr <= '0;
            ws1   <= '0;
            ws2   <= '0;
        end else begin
            if (wr_en) w_ptr <= w_ptr + 1'b1;
            ws1 <= w_ptr;
            ws2 <= ws1;
        end
    end

    always @(posedge clk) begin
        if (wr_en && reset) mem[w_ptr] <= wr_data;
        if (bus_if.mem_rd_en) rd_data_q <= mem[bus_if.r_add];
    end

    assign bus_if.comp_empty  = (bus_if.r_add == ws2);
    assign bus_if.mem_rd_data = rd_data_q;

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard and per-cycle protocol monitor.
    logic [7:0]  exp_q [$];
    int unsigned cyc_cnt = 0, fetch_total = 0, acc_total = 0, wr_total = 0, wrap_cnt = 0;
    int unsigned last_acc = 0;
    bit          have_last = 1'b0;
    bit          burst_chk = 1'b0;
    addr_t       model_radd = '0, prev_radd = '0;
    logic [15:0] model_cnt = '0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_acc = 1'b0;
    logic [7:0]  prev_data = '0;

    always @(negedge clk) begin
        cyc_cnt++;
        if (!reset) begin
            model_radd = '0;
            model_cnt  = '0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_acc   = 1'b0;
            prev_radd  = '0;
            exp_q.delete();
        end else begin
            check_eq("r_add", 32'(bus_if.r_add), 32'(model_radd));
            check_eq("rd_count", 32'(bus_if.rd_count), 32'(model_cnt));
            check_eq("fetch_valid_excl", 32'(bus_if.mem_rd_en & bus_if.rx_valid), 32'd0);
            if (prev_acc) check_eq("valid_drop", 32'(bus_if.rx_valid), 32'd0);
            if (prev_valid && !prev_ready) begin
                check_eq("stall_valid", 32'(bus_if.rx_valid), 32'd1);
                check_eq("stall_data", 32'(bus_if.rx_data), 32'(prev_data));
                check_eq("stall_fetch", 32'(bus_if.mem_rd_en), 32'd0);
            end
            if (prev_radd == '1 && bus_if.r_add == '0) wrap_cnt++;
            if (bus_if.mem_rd_en) begin
                fetch_total++;
                model_radd = model_radd + 1'b1;
            end
            if (bus_if.rx_valid && bus_if.rx_ready) begin
                acc_total++;
                model_cnt = model_cnt + 16'd1;
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("rx_data", 32'(bus_if.rx_data), 32'(exp_q.pop_front()));
                if (burst_chk) begin
                    if (have_last) check_eq("burst_gap", cyc_cnt - last_acc, 32'd3);
                    last_acc  = cyc_cnt;
                    have_last = 1'b1;
                end
            end
            prev_acc   = bus_if.rx_valid & bus_if.rx_ready;
            prev_valid = bus_if.rx_valid;
            prev_ready = bus_if.rx_ready;
            prev_data  = bus_if.rx_data;
            prev_radd  = bus_if.r_add;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [7:0] d);
        cyc();
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        wr_total++;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic wait_valid(input int unsigned max_cyc);
        for (int i = 0; i < int'(max_cyc) && !bus_if.rx_valid; i++) cyc();
        check_eq("wait_valid", 32'(bus_if.rx_valid), 32'd1);
    endtask

    task automatic accept_one();
        wait_valid(30);
        bus_if.rx_ready = 1'b1;
        cyc();
        bus_if.rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0, a0, w0, wr0;
        reset           = 1'b0;
        wr_en           = 1'b0;
        wr_data         = '0;
        bus_if.rx_ready = 1'b0;

        // Reset values, then 20 idle cycles with the FIFO empty.
        repeat (3) cyc();
        check_eq("rst_r_add", 32'(bus_if.r_add), 32'd0);
        check_eq("rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
        check_eq("rst_mem_rd_en", 32'(bus_if.mem_rd_en), 32'd0);
        check_eq("rst_rd_count", 32'(bus_if.rd_count), 32'd0);
        reset = 1'b1;
        repeat (20) cyc();
        check_eq("idle_no_fetch", fetch_total, 32'd0);
        check_eq("idle_no_valid", 32'(bus_if.rx_valid), 32'd0);

        // Single word: exact latency from comp_empty falling.
        push_word(8'hA5);
        for (int i = 0; i < 10 && bus_if.comp_empty; i++) cyc();
        check_eq("ce_fall", 32'(bus_if.comp_empty), 32'd0);
        cyc();
        check_eq("sw_fetch", 32'(bus_if.mem_rd_en), 32'd1);
        check_eq("sw_r_add0", 32'(bus_if.r_add), 32'd0);
        cyc();
        check_eq("sw_fetch_once", 32'(bus_if.mem_rd_en), 32'd0);
        check_eq("sw_r_add1", 32'(bus_if.r_add), 32'd1);
        check_eq("sw_not_valid", 32'(bus_if.rx_valid), 32'd0);
        cyc();
        check_eq("sw_valid", 32'(bus_if.rx_valid), 32'd1);
        check_eq("sw_data", 32'(bus_if.rx_data), 32'hA5);
        cyc();
        cyc();
        bus_if.rx_ready = 1'b1;
        cyc();
        bus_if.rx_ready = 1'b0;
        check_eq("sw_valid_drop", 32'(bus_if.rx_valid), 32'd0);
        check_eq("sw_rd_count", 32'(bus_if.rd_count), 32'd1);
        check_eq("sw_idle", 32'(bus_if.mem_rd_en), 32'd0);

        // Stall 50 cycles in VALID, then accept; next fetch follows at once.
        push_word(8'hB1);
        push_word(8'hB2);
        wait_valid(20);
        f0 = fetch_total;
        repeat (50) cyc();
        check_eq("stall_hold_data", 32'(bus_if.rx_data), 32'hB1);
        check_eq("stall_hold_valid", 32'(bus_if.rx_valid), 32'd1);
        check_eq("stall_no_fetch", fetch_total - f0, 32'd0);
        bus_if.rx_ready = 1'b1;
        cyc();
        bus_if.rx_ready = 1'b0;
        check_eq("refetch", 32'(bus_if.mem_rd_en), 32'd1);
        accept_one();
        repeat (5) cyc();

        // Burst of Depth+3 words from a fresh reset: in order, every 3 cycles, one wrap.
        do_reset();
        repeat (3) cyc();
        f0              = fetch_total;
        a0              = acc_total;
        w0              = wrap_cnt;
        wr0             = wr_total;
        have_last       = 1'b0;
        burst_chk       = 1'b1;
        bus_if.rx_ready = 1'b1;
        for (int k = 0; k < int'(Depth) + 3; k++) begin
            for (int t = 0; t < 200 && ((wr_total - wr0) - (fetch_total - f0)) >= Depth - 1; t++)
                cyc();
            push_word(8'(k));
        end
        for (int t = 0; t < 400 && (acc_total - a0) < Depth + 3; t++) cyc();
        burst_chk = 1'b0;
        bus_if.rx_ready = 1'b0;
        check_eq("burst_words", acc_total - a0, Depth + 3);
        check_eq("burst_rd_count", 32'(bus_if.rd_count), Depth + 3);
        check_eq("burst_wraps", wrap_cnt - w0, 32'd1);
        check_eq("burst_r_add", 32'(bus_if.r_add), 32'd3);
        repeat (3) cyc();

        // FIFO runs dry on word 4: back to IDLE without an extra fetch.
        f0              = fetch_total;
        a0              = acc_total;
        bus_if.rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_word(8'h40 + 8'(k));
        for (int t = 0; t < 100 && (acc_total - a0) < 4; t++) cyc();
        repeat (10) cyc();
        bus_if.rx_ready = 1'b0;
        check_eq("dry_accepts", acc_total - a0, 32'd4);
        check_eq("dry_fetches", fetch_total - f0, 32'd4);
        check_eq("dry_valid", 32'(bus_if.rx_valid), 32'd0);
        check_eq("dry_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset pulse during CAPTURE clears everything asynchronously.
        push_word(8'hC1);
        push_word(8'hC2);
        for (int i = 0; i < 20 && !bus_if.mem_rd_en; i++) cyc();
        check_eq("pre_rst_fetch", 32'(bus_if.mem_rd_en), 32'd1);
        cyc();
        reset = 1'b0;
        #1;
        check_eq("arst_r_add", 32'(bus_if.r_add), 32'd0);
        check_eq("arst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
        check_eq("arst_rx_data", 32'(bus_if.rx_data), 32'd0);
        check_eq("arst_rd_count", 32'(bus_if.rd_count), 32'd0);
        check_eq("arst_mem_rd_en", 32'(bus_if.mem_rd_en), 32'd0);
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        check_eq("post_rst_idle", 32'(bus_if.mem_rd_en), 32'd0);
        push_word(8'h5A);
        push_word(8'h5B);
        accept_one();
        accept_one();
        repeat (3) cyc();
        check_eq("resume_r_add", 32'(bus_if.r_add), 32'd2);
        check_eq("resume_rd_count", 32'(bus_if.rd_count), 32'd2);
        check_eq("resume_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_reader.md
# uart_rx_fifo_reader

Processor-clock-domain read controller for the UART-to-processor asynchronous FIFO. It owns the binary read pointer `r_add` and drives it into the empty-comparison stage, which returns `comp_empty`. While the FIFO is not empty it fetches one word at a time from the FIFO's synchronous memory read port. Each word is presented to the processor on a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, default 8: width of a FIFO word (one UART byte).
- Pointer width is not a parameter. It is fixed by the `ADDR_W` type in `DataTypes`.

Ports:
- `processor_clk`  in  1  processor clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `comp_empty`  in  1  from the empty comparator; 1 when `r_add` equals the synchronized write pointer.
- `r_add`  out  `ADDR_W`  binary read pointer; goes to the comparator and to the memory read address.
- `mem_rd_en`  out  1  memory read strobe; memory samples `r_add` at the edge ending this cycle.
- `mem_rd_data`  in  `DATA_W`  memory read data; valid the cycle after `mem_rd_en`.
- `rx_data`  out  `DATA_W`  word presented to the processor.
- `rx_valid`  out  1  `rx_data` is valid.
- `rx_ready`  in  1  processor accepts the word.
- `rd_count`  out  16  count of words delivered; wraps at 2^16.

## Operation
FSM states: `IDLE`, `FETCH`, `CAPTURE`, `VALID`.
- **`IDLE`**
  - If `comp_empty` is 0, go to `FETCH`; otherwise stay.
  - The processor never sees a read while empty.
- **`FETCH`**
  - `mem_rd_en` = 1 (Moore output, this state only).
  - At the closing edge, `r_add` <= `r_add` + 1, wrapping 2^ADDR_W−1 → 0.
  - Next state: `CAPTURE`.
- **`CAPTURE`**
  - `rx_data` <= `mem_rd_data` and `rx_valid` <= 1.
  - Next state: `VALID`.
- **`VALID`**
  - `rx_data` and `rx_valid` are held stable until `rx_valid`·`rx_ready` = 1 at an edge.
  - At that edge: `rd_count` increments and `rx_valid` <= 0.
  - Next state is `FETCH` if `comp_empty` is 0 in that cycle, else `IDLE`.
- **Outputs outside `VALID`:** `rx_valid` = 0; `rx_ready` is ignored.
- **Pointer behaviour**
  - `r_add` changes only on the `FETCH` edge.
  - `comp_empty` is re-evaluated by the comparator against the new `r_add` combinationally.
  - Pointer wrap needs no special handling.
- **Write-pointer latency:** the write pointer reaches the comparator through a 2-FF synchronizer. A freshly written word may therefore keep `comp_empty` at 1 for up to 2 extra cycles; this is correct behaviour, not an error.
- **Reset (any time, including mid-fetch or mid-handshake):**
  - Return to `IDLE`.
  - `r_add` = 0, `rx_valid` = 0, `rx_data` = 0, `rd_count` = 0, `mem_rd_en` = 0.
  - Any in-flight word is discarded.

## Timing
- `comp_empty` falls in cycle N while in `IDLE`:
  - `FETCH` in N+1.
  - `CAPTURE` in N+2.
  - `rx_valid` = 1 from N+3.
- Back-to-back operation with `rx_ready` tied high:
  - One word every 3 cycles.
  - `rx_valid` is high for 1 cycle per word.
  - `rx_valid` is never high for two consecutive cycles.
- `rx_ready` asserted before `rx_valid`: no effect until `VALID`.
- `rx_ready` deasserted in `VALID`: stall indefinitely with `rx_data` unchanged; no further `FETCH`.
- All outputs are registered or pure state decodes; there are no combinational paths from inputs to outputs.

## Structure
- `DataTypes` holds:
  - `ADDR_W` (existing).
  - New enum `rd_state_t` {`IDLE`, `FETCH`, `CAPTURE`, `VALID`}.
  - Constant `UART_DATA_W` = 8, used as the `DATA_W` default.
- One sub-module, `rd_ptr_counter`: `ADDR_W` binary counter with increment enable and asynchronous active-low clear, producing `r_add`.
- The FSM, data register and `rd_count` live in the top.

## Test plan
- **Reset value:** assert `reset` = 0 with `comp_empty` = 1 → `r_add` = 0, `rx_valid` = 0, `mem_rd_en` = 0, `rd_count` = 0; block stays in `IDLE` for 20 cycles.
- **Single word:** `comp_empty` drops in cycle 10, memory returns 0xA5 → `mem_rd_en` high in cycle 11 only, `r_add` = 1 from cycle 12, `rx_valid` with `rx_data` = 0xA5 from cycle 13; `rx_ready` = 1 in cycle 15 → `rd_count` = 1, `rx_valid` = 0 in cycle 16.
- **Stall:** `rx_ready` = 0 for 50 cycles in `VALID` → `rx_data` is stable and `mem_rd_en` stays 0; accept → next `FETCH` follows immediately if not empty.
- **Burst and wrap:** preload 2^ADDR_W + 3 words (0x00 upward) via a writer model, `rx_ready` = 1 → words are delivered in order every 3 cycles; `r_add` wraps to 0 exactly once; final `rd_count` = 2^ADDR_W + 3.
- **Empty mid-burst:** `comp_empty` rises during the accepting cycle of word 4 → block returns to `IDLE`; no extra `mem_rd_en`.
- **Reset mid-operation:** `reset` pulses low during `CAPTURE` → all outputs clear asynchronously; after release the block resumes from `r_add` = 0.
